// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-stage stall/squash from memory handshakes, redirects,
// load-use and CSR flushes, plus a dmem stall watchdog. Optional perf counters: HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int NUM_STAGES    = 5,
  parameter int FLUSH_CYCLES  = 2,
  parameter int STALL_TIMEOUT = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic                  dmem_expected_i,
  input  logic                  redirect_i,
  input  logic                  csr_flush_i,
  input  logic                  load_use_stall_i,
  input  logic                  timeout_clr_i,
  output logic [NUM_STAGES-1:0] stage_stall_o,
  output logic [NUM_STAGES-1:0] stage_squash_o,
  output logic                  flush_busy_o,
  output logic                  timeout_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cycles_o,
  output logic [31:0]           perf_flushes_o
`endif
);

  localparam int              WD_W       = $clog2(STALL_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX     = WD_W'(STALL_TIMEOUT);
  localparam logic [3:0]      FLUSH_LOAD = 4'(FLUSH_CYCLES);

  logic            imem_stall;
  logic            dmem_stall;
  logic [3:0]      flush_cnt_q, flush_cnt_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_d;

  assign imem_stall = !(imem_gnt_i && imem_rvalid_i);
  assign dmem_stall = dmem_expected_i && !(dmem_gnt_i && dmem_rvalid_i);

  // A new CSR flush restarts the countdown even if one is already running.
  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (csr_flush_i)              flush_cnt_d = FLUSH_LOAD;
    else if (flush_cnt_q != 4'd0) flush_cnt_d = flush_cnt_q - 4'd1;
  end

  assign flush_busy_o = csr_flush_i | (flush_cnt_q != 4'd0);

  always_comb begin
    stage_stall_o     = {NUM_STAGES{dmem_stall}};
    stage_squash_o    = '0;
    stage_stall_o[0]  = imem_stall | dmem_stall | flush_busy_o | load_use_stall_i;
    stage_squash_o[0] = redirect_i;
    stage_stall_o[1]  = imem_stall | dmem_stall | load_use_stall_i;
    stage_squash_o[1] = redirect_i | flush_busy_o;
    stage_squash_o[2] = load_use_stall_i | imem_stall;
  end

  // Timeout is set on the same edge the counter reaches its limit; clear beats set.
  always_comb begin
    wd_cnt_d  = '0;
    timeout_d = timeout_o;
    if (timeout_clr_i) begin
      wd_cnt_d  = '0;
      timeout_d = 1'b0;
    end else if (dmem_stall) begin
      wd_cnt_d = (wd_cnt_q == WD_MAX) ? WD_MAX : wd_cnt_q + WD_W'(1);
      if (wd_cnt_d == WD_MAX) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flush_cnt_q <= 4'd0;
      wd_cnt_q    <= '0;
      timeout_o   <= 1'b0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      timeout_o   <= timeout_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic flush_busy_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flush_busy_q        <= 1'b0;
      perf_stall_cycles_o <= 32'd0;
      perf_flushes_o      <= 32'd0;
    end else begin
      flush_busy_q <= flush_busy_o;
      if (stage_stall_o[0] && (perf_stall_cycles_o != 32'hFFFF_FFFF))
        perf_stall_cycles_o <= perf_stall_cycles_o + 32'd1;
      if (flush_busy_o && !flush_busy_q && (perf_flushes_o != 32'hFFFF_FFFF))
        perf_flushes_o <= perf_flushes_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a 5-stage/2-cycle-flush instance and a
// 7-stage/0-cycle-flush instance share one stimulus stream.
module tb_hazard_ctrl;

  // vector bits: rst_n imem_gnt imem_rvalid dmem_gnt dmem_rvalid | dmem_exp redirect csr load_use clr
  localparam logic [9:0] V_IDLE   = 10'b11111_00000;
  localparam logic [9:0] V_RST    = 10'b01111_00000;
  localparam logic [9:0] V_IMISS  = 10'b11011_00000;
  localparam logic [9:0] V_DSTALL = 10'b11110_10000;
  localparam logic [9:0] V_CSR    = 10'b11111_00100;
  localparam logic [9:0] V_RED_LU = 10'b11111_01010;
  localparam logic [9:0] V_RED    = 10'b11111_01000;
  localparam logic [9:0] V_CLR    = 10'b11111_00001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic imem_gnt = 1'b1, imem_rvalid = 1'b1, dmem_gnt = 1'b1, dmem_rvalid = 1'b1;
  logic dmem_exp = 1'b0, redirect = 1'b0, csr_flush = 1'b0, load_use = 1'b0, to_clr = 1'b0;

  logic [4:0] stall5, squash5;
  logic [6:0] stall7, squash7;
  logic       busy5, busy7, to5, to7;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] pstall5, pflush5, pstall7, pflush7;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [27:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.NUM_STAGES(5), .FLUSH_CYCLES(2), .STALL_TIMEOUT(255)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_gnt_i(imem_gnt), .imem_rvalid_i(imem_rvalid),
    .dmem_gnt_i(dmem_gnt), .dmem_rvalid_i(dmem_rvalid),
    .dmem_expected_i(dmem_exp), .redirect_i(redirect), .csr_flush_i(csr_flush),
    .load_use_stall_i(load_use), .timeout_clr_i(to_clr),
    .stage_stall_o(stall5), .stage_squash_o(squash5),
    .flush_busy_o(busy5), .timeout_o(to5)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cycles_o(pstall5), .perf_flushes_o(pflush5)
`endif
  );

  hazard_ctrl #(.NUM_STAGES(7), .FLUSH_CYCLES(0), .STALL_TIMEOUT(255)) dut7 (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_gnt_i(imem_gnt), .imem_rvalid_i(imem_rvalid),
    .dmem_gnt_i(dmem_gnt), .dmem_rvalid_i(dmem_rvalid),
    .dmem_expected_i(dmem_exp), .redirect_i(redirect), .csr_flush_i(csr_flush),
    .load_use_stall_i(load_use), .timeout_clr_i(to_clr),
    .stage_stall_o(stall7), .stage_squash_o(squash7),
    .flush_busy_o(busy7), .timeout_o(to7)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cycles_o(pstall7), .perf_flushes_o(pflush7)
`endif
  );

  // Drives one cycle of inputs just after the edge; optionally queues the expected response.
  task automatic step(input logic [9:0] v, input logic [4:0] s5, input logic [4:0] q5,
                      input logic b5, input logic t, input logic [6:0] s7, input logic [6:0] q7,
                      input logic b7, input string nm, input bit chk);
    @(posedge clk);
    #1;
    {rst_n, imem_gnt, imem_rvalid, dmem_gnt, dmem_rvalid,
     dmem_exp, redirect, csr_flush, load_use, to_clr} = v;
    if (chk) begin
      exp_q.push_back({s5, q5, b5, t, s7, q7, b7, t});
      name_q.push_back(nm);
    end
  endtask

  task automatic drive(input logic [9:0] v);
    step(v, 5'b0, 5'b0, 1'b0, 1'b0, 7'b0, 7'b0, 1'b0, "", 1'b0);
  endtask

  always @(negedge clk) begin
    logic [27:0] e, a;
    string       nm;
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {stall5, squash5, busy5, to5, stall7, squash7, busy7, to7};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s: got %b required %b", nm, a, e);
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask
`endif

  initial begin
    step(V_RST,  5'b00000, 5'b00000, 0, 0, 7'b0000000, 7'b0000000, 0, "reset", 1);
    step(V_IDLE, 5'b00000, 5'b00000, 0, 0, 7'b0000000, 7'b0000000, 0, "idle", 1);
    step(V_IMISS, 5'b00011, 5'b00100, 0, 0, 7'b0000011, 7'b0000100, 0, "imiss", 1);
    step(V_IDLE, 5'b00000, 5'b00000, 0, 0, 7'b0000000, 7'b0000000, 0, "imiss_recover", 1);

    // single CSR flush pulse
    step(V_CSR,  5'b00001, 5'b00010, 1, 0, 7'b0000001, 7'b0000010, 1, "flush_t0", 1);
    step(V_IDLE, 5'b00001, 5'b00010, 1, 0, 7'b0000000, 7'b0000000, 0, "flush_t1", 1);
    step(V_IDLE, 5'b00001, 5'b00010, 1, 0, 7'b0000000, 7'b0000000, 0, "flush_t2", 1);
    step(V_IDLE, 5'b00000, 5'b00000, 0, 0, 7'b0000000, 7'b0000000, 0, "flush_end", 1);

    // retrigger on second cycle stretches busy to four cycles
    step(V_CSR,  5'b00001, 5'b00010, 1, 0, 7'b0000001, 7'b0000010, 1, "retrig_t0", 1);
    step(V_CSR,  5'b00001, 5'b00010, 1, 0, 7'b0000001, 7'b0000010, 1, "retrig_t1", 1);
    step(V_IDLE, 5'b00001, 5'b00010, 1, 0, 7'b0000000, 7'b0000000, 0, "retrig_t2", 1);
    step(V_IDLE, 5'b00001, 5'b00010, 1, 0, 7'b0000000, 7'b0000000, 0, "retrig_t3", 1);
    step(V_IDLE, 5'b00000, 5'b00000, 0, 0, 7'b0000000, 7'b0000000, 0, "retrig_end", 1);

    step(V_RED_LU, 5'b00011, 5'b00111, 0, 0, 7'b0000011, 7'b0000111, 0, "redirect_loaduse", 1);
    step(V_RED,    5'b00000, 5'b00011, 0, 0, 7'b0000000, 7'b0000011, 0, "redirect_only", 1);
    step(10'b11010_10000, 5'b11111, 5'b00100, 0, 0, 7'b1111111, 7'b0000100, 0, "imem_dmem_stall", 1);
    step(10'b11101_10000, 5'b11111, 5'b00000, 0, 0, 7'b1111111, 7'b0000000, 0, "dmem_no_gnt", 1);
    step(10'b11110_00000, 5'b00000, 5'b00000, 0, 0, 7'b0000000, 7'b0000000, 0, "dmem_not_expected", 1);

    // async reset in the middle of a flush
    step(V_CSR,  5'b00001, 5'b00010, 1, 0, 7'b0000001, 7'b0000010, 1, "rflush_t0", 1);
    step(V_IDLE, 5'b00001, 5'b00010, 1, 0, 7'b0000000, 7'b0000000, 0, "rflush_t1", 1);
    step(V_RST,  5'b00000, 5'b00000, 0, 0, 7'b0000000, 7'b0000000, 0, "rflush_reset", 1);
    step(V_IDLE, 5'b00000, 5'b00000, 0, 0, 7'b0000000, 7'b0000000, 0, "rflush_after", 1);

    // continuous dmem stall: timeout appears on the 255th stall cycle after the start
    for (int i = 0; i < 256; i++)
      step(V_DSTALL, 5'b11111, 5'b00000, 0, (i >= 255), 7'b1111111, 7'b0000000, 0,
           $sformatf("wd_stall_%0d", i), (i == 0 || i == 254 || i == 255));
    step(V_IDLE, 5'b00000, 5'b00000, 0, 1, 7'b0000000, 7'b0000000, 0, "wd_sticky", 1);
    step(V_CLR,  5'b00000, 5'b00000, 0, 1, 7'b0000000, 7'b0000000, 0, "wd_clr_cycle", 1);
    step(V_IDLE, 5'b00000, 5'b00000, 0, 0, 7'b0000000, 7'b0000000, 0, "wd_cleared", 1);

    // 254-cycle stall stays short of the limit
    for (int i = 0; i < 254; i++)
      step(V_DSTALL, 5'b11111, 5'b00000, 0, 0, 7'b1111111, 7'b0000000, 0, "wd254_last", (i == 253));
    step(V_IDLE, 5'b00000, 5'b00000, 0, 0, 7'b0000000, 7'b0000000, 0, "wd254_after", 1);
    step(V_IDLE, 5'b00000, 5'b00000, 0, 0, 7'b0000000, 7'b0000000, 0, "wd254_after2", 1);

    // clear on the cycle the counter would hit the limit wins
    for (int i = 0; i < 254; i++) drive(V_DSTALL);
    step(10'b11110_10001, 5'b11111, 5'b00000, 0, 0, 7'b1111111, 7'b0000000, 0, "wd_clr_vs_set", 1);
    step(V_IDLE, 5'b00000, 5'b00000, 0, 0, 7'b0000000, 7'b0000000, 0, "wd_clr_won", 1);

    // async reset mid-stall zeroes the watchdog count
    for (int i = 0; i < 100; i++) drive(V_DSTALL);
    step(V_RST, 5'b00000, 5'b00000, 0, 0, 7'b0000000, 7'b0000000, 0, "wd_reset", 1);
    for (int i = 0; i < 200; i++)
      step(V_DSTALL, 5'b11111, 5'b00000, 0, 0, 7'b1111111, 7'b0000000, 0, "wd_after_reset", (i == 199));
    step(V_IDLE, 5'b00000, 5'b00000, 0, 0, 7'b0000000, 7'b0000000, 0, "wd_after_reset_idle", 1);

`ifdef HAZARD_PERF_CNT_EN
    drive(V_RST);
    for (int i = 0; i < 10; i++) drive(V_IMISS);
    drive(V_IDLE);
    drive(V_CSR); drive(V_IDLE); drive(V_IDLE); drive(V_IDLE);
    drive(V_CSR); drive(V_IDLE); drive(V_IDLE); drive(V_IDLE);
    @(negedge clk);
    #2;
    check32("perf_stall5", pstall5, 32'd16);
    check32("perf_flush5", pflush5, 32'd2);
    check32("perf_stall7", pstall7, 32'd12);
    check32("perf_flush7", pflush7, 32'd2);
`endif

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
